// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data access
//   Data requests have priority. A waiting fetch is granted once MAX_WAIT data grants
//   have gone by. Reads with no inputReady end after TIMEOUT cycles and return all ones.
//   Ports:
//     clk, reset                               clock, async active-high reset
//     i_req/i_addr -> i_grant/i_rdata/i_valid  fetch requester
//     d_req/d_we/d_addr/d_wdata -> d_grant/d_rdata/d_valid  data requester
//     readM/writeM/address/data/inputReady     memory port (data is bidirectional)
//     busy, timeout_err                        status (timeout_err is sticky)
module mem_port_arbiter #(
   parameter int WORD_SIZE    = 16,
   parameter int WRITE_CYCLES = 2,
   parameter int MAX_WAIT     = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_req,
   input  logic [WORD_SIZE-1:0] i_addr,
   output logic                 i_grant,
   output logic [WORD_SIZE-1:0] i_rdata,
   output logic                 i_valid,
   input  logic                 d_req,
   input  logic                 d_we,
   input  logic [WORD_SIZE-1:0] d_addr,
   input  logic [WORD_SIZE-1:0] d_wdata,
   output logic                 d_grant,
   output logic [WORD_SIZE-1:0] d_rdata,
   output logic                 d_valid,
   output logic                 readM,
   output logic                 writeM,
   output logic [WORD_SIZE-1:0] address,
   inout  wire  [WORD_SIZE-1:0] data,
   input  logic                 inputReady,
   output logic                 busy,
   output logic                 timeout_err
);
   localparam int CW = $clog2((TIMEOUT > WRITE_CYCLES ? TIMEOUT : WRITE_CYCLES) + 1);
   localparam int SW = $clog2(MAX_WAIT + 1);
   typedef enum logic [1:0] {IDLE, I_RD, D_RD, D_WR} state_t;
   state_t r_state, w_state;
   logic [CW-1:0] r_cnt, w_cnt;
   logic [SW-1:0] r_starve, w_starve;
   logic [WORD_SIZE-1:0] r_addr, w_addr, r_wdata, w_wdata;
   logic [WORD_SIZE-1:0] r_i_rdata, w_i_rdata, r_d_rdata, w_d_rdata;
   logic r_i_grant, w_i_grant, r_d_grant, w_d_grant;
   logic r_i_valid, w_i_valid, r_d_valid, w_d_valid;
   logic r_terr, w_terr, r_rd, r_wr, r_busy;
   logic w_fetch, w_rd_done;
   logic [WORD_SIZE-1:0] w_rd_val;
   // fetch wins when data is idle, or when data has starved it MAX_WAIT times
   assign w_fetch   = i_req && (!d_req || r_starve == SW'(MAX_WAIT));
   assign w_rd_done = inputReady || r_cnt == CW'(TIMEOUT - 1);
   assign w_rd_val  = inputReady ? data : '1;
   always_comb begin
      w_state   = r_state;
      w_cnt     = r_cnt;
      w_starve  = r_starve;
      w_addr    = r_addr;
      w_wdata   = r_wdata;
      w_i_rdata = r_i_rdata;
      w_d_rdata = r_d_rdata;
      w_i_grant = 1'b0;
      w_d_grant = 1'b0;
      w_i_valid = 1'b0;
      w_d_valid = 1'b0;
      w_terr    = r_terr;
      case (r_state)
         IDLE: begin
            w_cnt = '0;
            if (w_fetch) begin
               w_state   = I_RD;
               w_i_grant = 1'b1;
               w_addr    = i_addr;
               w_starve  = '0;
            end else if (d_req) begin
               w_state   = d_we ? D_WR : D_RD;
               w_d_grant = 1'b1;
               w_addr    = d_addr;
               w_wdata   = d_wdata;
               w_starve  = i_req ? r_starve + SW'(1) : '0;
            end else
               w_starve = '0;
         end
         I_RD, D_RD: begin
            if (w_rd_done) begin
               w_state = IDLE;
               w_terr  = r_terr | !inputReady;
               if (r_state == I_RD) begin
                  w_i_valid = 1'b1;
                  w_i_rdata = w_rd_val;
               end else begin
                  w_d_valid = 1'b1;
                  w_d_rdata = w_rd_val;
               end
            end else
               w_cnt = r_cnt + CW'(1);
         end
         default: begin
            if (r_cnt == CW'(WRITE_CYCLES - 1)) begin
               w_state   = IDLE;
               w_d_valid = 1'b1;
            end else
               w_cnt = r_cnt + CW'(1);
         end
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_starve  <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_i_rdata <= '0;
         r_d_rdata <= '0;
         r_i_grant <= 1'b0;
         r_d_grant <= 1'b0;
         r_i_valid <= 1'b0;
         r_d_valid <= 1'b0;
         r_terr    <= 1'b0;
         r_rd      <= 1'b0;
         r_wr      <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_cnt     <= w_cnt;
         r_starve  <= w_starve;
         r_addr    <= w_addr;
         r_wdata   <= w_wdata;
         r_i_rdata <= w_i_rdata;
         r_d_rdata <= w_d_rdata;
         r_i_grant <= w_i_grant;
         r_d_grant <= w_d_grant;
         r_i_valid <= w_i_valid;
         r_d_valid <= w_d_valid;
         r_terr    <= w_terr;
         r_rd      <= w_state == I_RD || w_state == D_RD;
         r_wr      <= w_state == D_WR;
         r_busy    <= w_state != IDLE;
      end
   end
   assign data        = r_wr ? r_wdata : 'z;
   assign i_grant     = r_i_grant;
   assign i_rdata     = r_i_rdata;
   assign i_valid     = r_i_valid;
   assign d_grant     = r_d_grant;
   assign d_rdata     = r_d_rdata;
   assign d_valid     = r_d_valid;
   assign readM       = r_rd;
   assign writeM      = r_wr;
   assign address     = r_addr;
   assign busy        = r_busy;
   assign timeout_err = r_terr;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
   logic clk = 1'b0, reset = 1'b1;
   logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, inputReady = 1'b0;
   logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
   logic i_grant, i_valid, d_grant, d_valid, readM, writeM, busy, timeout_err;
   logic [15:0] i_rdata, d_rdata, address;
   wire  [15:0] data;
   logic drv = 1'b0;
   logic [15:0] drv_val = '0;
   int n_run = 0, n_fail = 0;
   assign data = drv ? drv_val : 'z;
   always #5 clk = ~clk;
   mem_port_arbiter dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_rdata(i_rdata), .i_valid(i_valid),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_grant(d_grant), .d_rdata(d_rdata), .d_valid(d_valid),
      .readM(readM), .writeM(writeM), .address(address), .data(data),
      .inputReady(inputReady), .busy(busy), .timeout_err(timeout_err)
   );
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   initial begin
      tick();
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_readM", readM, 0);
      chk("rst_writeM", writeM, 0);
      chk("rst_addr", address, 0);
      chk("rst_terr", timeout_err, 0);
      reset = 1'b0;
      tick();
      // data read, inputReady three cycles after readM
      d_req = 1'b1; d_addr = 16'h0040;
      tick();
      chk("rd_dgrant", d_grant, 1);
      chk("rd_readM", readM, 1);
      chk("rd_addr", address, 16'h0040);
      chk("rd_busy", busy, 1);
      d_req = 1'b0;
      tick();
      chk("rd_grant_pulse", d_grant, 0);
      tick();
      chk("rd_wait_readM", readM, 1);
      inputReady = 1'b1; drv = 1'b1; drv_val = 16'h1234;
      tick();
      chk("rd_dvalid", d_valid, 1);
      chk("rd_rdata", d_rdata, 16'h1234);
      chk("rd_readM_drop", readM, 0);
      inputReady = 1'b0; drv = 1'b0;
      tick();
      chk("rd_dvalid_pulse", d_valid, 0);
      // stray inputReady in IDLE must be ignored
      inputReady = 1'b1; drv = 1'b1; drv_val = 16'h5555;
      tick();
      inputReady = 1'b0; drv = 1'b0;
      chk("stray_busy", busy, 0);
      chk("stray_ivalid", i_valid, 0);
      i_req = 1'b1; i_addr = 16'h0100;
      tick();
      chk("f_igrant", i_grant, 1);
      chk("f_addr", address, 16'h0100);
      i_req = 1'b0;
      tick();
      tick();
      chk("f_wait_readM", readM, 1);
      chk("f_wait_ivalid", i_valid, 0);
      inputReady = 1'b1; drv = 1'b1; drv_val = 16'hABCD;
      tick();
      chk("f_ivalid", i_valid, 1);
      chk("f_rdata", i_rdata, 16'hABCD);
      inputReady = 1'b0; drv = 1'b0;
      tick();
      // write of 0xBEEF held for two cycles
      d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0010; d_wdata = 16'hBEEF;
      tick();
      chk("wr_dgrant", d_grant, 1);
      chk("wr_writeM1", writeM, 1);
      chk("wr_readM1", readM, 0);
      chk("wr_data1", data, 16'hBEEF);
      chk("wr_addr", address, 16'h0010);
      d_req = 1'b0;
      tick();
      chk("wr_writeM2", writeM, 1);
      chk("wr_data2", data, 16'hBEEF);
      chk("wr_dvalid_early", d_valid, 0);
      tick();
      chk("wr_writeM_drop", writeM, 0);
      chk("wr_dvalid", d_valid, 1);
      chk("wr_data_released", data === 16'hBEEF, 0);
      tick();
      chk("wr_dvalid_pulse", d_valid, 0);
      d_we = 1'b0;
      // both requesters held: D,D,D,D,I,D
      d_req = 1'b1; i_req = 1'b1; inputReady = 1'b1; drv = 1'b1; drv_val = 16'h0000;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk($sformatf("arb%0d_d", k), d_grant, k == 4 ? 0 : 1);
         chk($sformatf("arb%0d_i", k), i_grant, k == 4 ? 1 : 0);
         tick();
      end
      d_req = 1'b0; i_req = 1'b0; inputReady = 1'b0; drv = 1'b0;
      tick();
      // fetch that never sees inputReady
      i_req = 1'b1; i_addr = 16'h0200;
      tick();
      chk("to_igrant", i_grant, 1);
      i_req = 1'b0;
      for (int k = 0; k < 254; k++) tick();
      chk("to_readM_held", readM, 1);
      chk("to_no_valid", i_valid, 0);
      chk("to_terr_early", timeout_err, 0);
      tick();
      chk("to_ivalid", i_valid, 1);
      chk("to_rdata", i_rdata, 16'hFFFF);
      chk("to_terr", timeout_err, 1);
      chk("to_readM_drop", readM, 0);
      tick();
      d_req = 1'b1; d_we = 1'b1; d_wdata = 16'h7777;
      tick();
      d_req = 1'b0;
      tick();
      tick();
      chk("to_wr_done", d_valid, 1);
      chk("to_terr_sticky", timeout_err, 1);
      tick();
      // reset between edges during a write
      d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0030; d_wdata = 16'h1111;
      tick();
      chk("rw_writeM", writeM, 1);
      d_req = 1'b0; d_we = 1'b0;
      #3 reset = 1'b1;
      #1;
      chk("rw_writeM_async", writeM, 0);
      chk("rw_busy_async", busy, 0);
      chk("rw_data_async", data === 16'h1111, 0);
      chk("rw_terr_cleared", timeout_err, 0);
      tick();
      chk("rw_no_dvalid", d_valid, 0);
      reset = 1'b0;
      tick();
      d_req = 1'b1; d_addr = 16'h0022;
      tick();
      chk("rw_post_dgrant", d_grant, 1);
      chk("rw_post_addr", address, 16'h0022);
      chk("rw_post_readM", readM, 1);
      d_req = 1'b0; inputReady = 1'b1; drv = 1'b1; drv_val = 16'h4242;
      tick();
      chk("rw_post_dvalid", d_valid, 1);
      chk("rw_post_rdata", d_rdata, 16'h4242);
      inputReady = 1'b0; drv = 1'b0;
      tick();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
